// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared datapath, handshaking with a variable-latency memory and counting retirements.
module multicycle_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             halt,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_wrt,
    output logic             ir_wrt,
    output logic             pc_wrt,
    output logic             pc_wrt_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             reg_wrt,
    output logic             mem_reg,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             illegal,
    output logic             mem_err
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ORIEX  = 4'd9,
        S_ORIWB  = 4'd10
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;

    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 2) + 1;
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_err_q;

    logic              fetch_idle_s;
    logic              to_hit_s;
    logic [WAIT_W-1:0] wait_inc_s;

    // Halt only counts before the fetch request has gone out (wait counter still zero).
    assign fetch_idle_s = (state_q == S_FETCH) && halt && (wait_q == WAIT_ZERO);
    assign to_hit_s     = (MEM_TIMEOUT > 0) && !mem_ack && (wait_q == WAIT_LAST);
    assign wait_inc_s   = (wait_q == {WAIT_W{1'b1}}) ? wait_q : wait_q + WAIT_ONE;

    assign state     = state_q;
    assign instr_cnt = cnt_q;
    assign mem_err   = mem_err_q;

    // State sequencing, memory wait counter, retire counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= WAIT_ZERO;
            cnt_q     <= {CNT_W{1'b0}};
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= 1'b0;
            wait_q    <= WAIT_ZERO;
            case (state_q)
                S_FETCH: begin
                    if (fetch_idle_s) begin
                        state_q <= S_FETCH;
                    end else if (mem_ack) begin
                        state_q <= S_DECODE;
                    end else if (to_hit_s) begin
                        state_q   <= S_FETCH;
                        mem_err_q <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                        wait_q  <= wait_inc_s;
                    end
                end
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_R:         state_q <= S_EXEC;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ORI:       state_q <= S_ORIEX;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_q <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD, S_MEMWR: begin
                    if (mem_ack) begin
                        state_q <= (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                        if (state_q == S_MEMWR) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end else if (to_hit_s) begin
                        state_q   <= S_FETCH;
                        mem_err_q <= 1'b1;
                    end else begin
                        state_q <= state_q;
                        wait_q  <= wait_inc_s;
                    end
                end
                S_EXEC:  state_q <= S_ALUWB;
                S_ORIEX: state_q <= S_ORIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ORIWB: begin
                    state_q <= S_FETCH;
                    cnt_q   <= cnt_q + CNT_ONE;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Moore datapath controls; ir_wrt/pc_wrt follow the fetch acknowledge.
    always_comb begin
        mem_req     = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_wrt     = 1'b0;
        ir_wrt      = 1'b0;
        pc_wrt      = 1'b0;
        pc_wrt_cond = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        reg_dst     = 1'b0;
        reg_wrt     = 1'b0;
        mem_reg     = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!fetch_idle_s) begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_wrt    = mem_ack;
                    pc_wrt    = mem_ack;
                end else begin
                    mem_req = 1'b0;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_ORI: illegal = 1'b0;
                    default:                            illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_wrt = 1'b1;
                mem_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_wrt = 1'b1;
                i_or_d  = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_wrt = 1'b1;
                reg_dst = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_op      = 2'b01;
                pc_wrt_cond = 1'b1;
                pc_src      = 2'b01;
            end
            S_ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_ORIWB: reg_wrt = 1'b1;
            default: mem_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle control trace from the phase description of the ISA and compared cycle by cycle.
module tb_multicycle_ctrl;

    localparam int CNT_W = 2;
    localparam int TO    = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       op;
    logic             halt;
    logic             mem_ack;
    logic             mem_req, i_or_d, mem_read, mem_wrt, ir_wrt, pc_wrt, pc_wrt_cond;
    logic [1:0]       pc_src, alu_src_b, alu_op;
    logic             alu_src_a, reg_dst, reg_wrt, mem_reg, illegal, mem_err;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    typedef struct packed {
        logic       mem_req;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_wrt;
        logic       ir_wrt;
        logic       pc_wrt;
        logic       pc_wrt_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       reg_wrt;
        logic       mem_reg;
        logic       illegal;
    } ctrl_t;

    ctrl_t dut_ctrl;
    assign dut_ctrl = {mem_req, i_or_d, mem_read, mem_wrt, ir_wrt, pc_wrt, pc_wrt_cond,
                       pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, reg_wrt, mem_reg, illegal};

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;

    multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .halt(halt), .mem_ack(mem_ack),
        .mem_req(mem_req), .i_or_d(i_or_d), .mem_read(mem_read), .mem_wrt(mem_wrt),
        .ir_wrt(ir_wrt), .pc_wrt(pc_wrt), .pc_wrt_cond(pc_wrt_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
        .reg_wrt(reg_wrt), .mem_reg(mem_reg), .state(state), .instr_cnt(instr_cnt),
        .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt = 0;
    bit m_err_pend = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] o);
        return (o == OP_R) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) || (o == OP_ORI);
    endfunction

    // One clock cycle: drive inputs, compare at the falling edge, advance past the rising edge.
    task automatic step(input bit h, input bit a, input logic [3:0] st, input ctrl_t e);
        halt    = h;
        mem_ack = a;
        @(negedge clk);
        check_val("state", 32'(state), 32'(st));
        check_val("ctrl", 32'(dut_ctrl), 32'(e));
        check_val("mem_err", 32'(mem_err), 32'(m_err_pend));
        check_val("instr_cnt", 32'(instr_cnt), 32'(m_cnt % (1 << CNT_W)));
        m_err_pend = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // A memory request phase acked after lat cycles; past TO cycles it aborts instead.
    task automatic mem_phase(input logic [3:0] st, input ctrl_t base, input int lat, output bit ok);
        ctrl_t e;
        int n;
        n = (lat > TO) ? TO : lat;
        for (int k = 1; k <= n; k++) begin
            e = base;
            if (k == lat && st == 4'd0) begin
                e.ir_wrt = 1'b1;
                e.pc_wrt = 1'b1;
            end
            step((k == 1 && st == 4'd0) ? 1'b0 : 1'($urandom % 2), (k == lat), st, e);
        end
        ok = (lat <= TO);
        if (!ok) m_err_pend = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] o, input int hcyc, input int flat, input int dlat);
        ctrl_t e;
        bit ok;
        op = o;
        for (int i = 0; i < hcyc; i++) step(1'b1, 1'b0, 4'd0, ctrl_t'(0));
        e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'b01;
        mem_phase(4'd0, e, flat, ok);
        if (!ok) return;
        e = '0; e.alu_src_b = 2'b11; e.illegal = !is_legal(o);
        step(1'($urandom % 2), 1'($urandom % 2), 4'd1, e);
        if (!is_legal(o)) return;
        if (o == OP_LW || o == OP_SW) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            step(1'($urandom % 2), 1'($urandom % 2), 4'd2, e);
            e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1;
            e.mem_read = (o == OP_LW); e.mem_wrt = (o == OP_SW);
            mem_phase((o == OP_LW) ? 4'd3 : 4'd5, e, dlat, ok);
            if (!ok) return;
            if (o == OP_LW) begin
                e = '0; e.reg_wrt = 1'b1; e.mem_reg = 1'b1;
                step(1'($urandom % 2), 1'($urandom % 2), 4'd4, e);
            end
        end else if (o == OP_R) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
            step(1'($urandom % 2), 1'($urandom % 2), 4'd6, e);
            e = '0; e.reg_wrt = 1'b1; e.reg_dst = 1'b1;
            step(1'($urandom % 2), 1'($urandom % 2), 4'd7, e);
        end else if (o == OP_BEQ) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_wrt_cond = 1'b1; e.pc_src = 2'b01;
            step(1'($urandom % 2), 1'($urandom % 2), 4'd8, e);
        end else begin
            e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b11;
            step(1'($urandom % 2), 1'($urandom % 2), 4'd9, e);
            e = '0; e.reg_wrt = 1'b1;
            step(1'($urandom % 2), 1'($urandom % 2), 4'd10, e);
        end
        m_cnt++;
    endtask

    task automatic do_reset(input int n);
        rst_n   = 1'b0;
        halt    = 1'b0;
        mem_ack = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_state", 32'(state), 32'd0);
            check_val("rst_cnt", 32'(instr_cnt), 32'd0);
            check_val("rst_reg_wrt", 32'(reg_wrt), 32'd0);
            check_val("rst_mem_err", 32'(mem_err), 32'd0);
        end
        rst_n      = 1'b1;
        m_cnt      = 0;
        m_err_pend = 1'b0;
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom % 10);
        if (r < 6) return 1;
        if (r < 8) return 2 + int'($urandom % 3);
        if (r == 8) return TO;
        return TO + 1;
    endfunction

    initial begin
        ctrl_t e;
        logic [5:0] o;
        rst_n = 1'b0; op = 6'd0; halt = 1'b0; mem_ack = 1'b0;
        do_reset(2);
        run_instr(OP_R, 0, 1, 1);
        run_instr(OP_LW, 0, 1, 3);
        run_instr(OP_BEQ, 0, 1, 1);
        run_instr(OP_ORI, 0, 1, 1);
        run_instr(6'b111111, 0, 1, 1);
        run_instr(OP_R, 2, 1, 1);
        run_instr(OP_SW, 0, 1, TO + 1);
        run_instr(OP_SW, 0, 1, TO);
        run_instr(OP_SW, 0, TO + 1, 1);
        // Reset while an R-type sits in EXEC.
        op = OP_R;
        e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.ir_wrt = 1'b1; e.pc_wrt = 1'b1;
        step(1'b0, 1'b1, 4'd0, e);
        e = '0; e.alu_src_b = 2'b11;
        step(1'b0, 1'b0, 4'd1, e);
        do_reset(2);
        e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'b01;
        step(1'b0, 1'b0, 4'd0, e);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, e);
        e.ir_wrt = 1'b1; e.pc_wrt = 1'b1;
        step(1'b1, 1'b1, 4'd0, e);
        e = '0; e.alu_src_b = 2'b11;
        step(1'b0, 1'b0, 4'd1, e);
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
        step(1'b0, 1'b0, 4'd6, e);
        e = '0; e.reg_wrt = 1'b1; e.reg_dst = 1'b1;
        step(1'b0, 1'b0, 4'd7, e);
        m_cnt++;
        for (int n = 0; n < 80; n++) begin
            case ($urandom % 6)
                0: o = OP_R;
                1: o = OP_LW;
                2: o = OP_SW;
                3: o = OP_BEQ;
                4: o = OP_ORI;
                default: begin
                    o = 6'($urandom);
                    while (is_legal(o)) o = 6'($urandom);
                end
            endcase
            run_instr(o, int'($urandom % 3), pick_lat(), pick_lat());
        end
        step(1'b1, 1'b0, 4'd0, ctrl_t'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
